wm_core: RTL and testbench
==========================

Name: wm_core

Overview:
- Execution core of the washing register machine; directly downstream of the program ROM.
- Drives the ROM address (pc), consumes the combinational 32-bit instruction, and executes it.
- Sequences the fill valve, drain valve and drum motor through register-based loops, with timed operations paced by an external tick.

Parameters:
- ADDR_WIDTH, 8: pc width; pc wraps modulo 2^ADDR_WIDTH.
- INSTR_WIDTH, 32: instruction width. Fields: [31:16] imm16, [15:8] reg index, [7:0] opcode.
- NUM_REGS, 4: number of 16-bit loop registers.
- START_ADDR, 2: pc loaded on a start pulse.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a program run from IDLE
- abort  in  1  level; forces IDLE and all actuators off
- tick  in  1  one-cycle time-base pulse (e.g. 1 s)
- instr  in  INSTR_WIDTH  instruction at pc, from the ROM (combinational)
- pc  out  ADDR_WIDTH  program counter to the ROM
- fill_valve  out  1  water inlet on
- drain_valve  out  1  drain on
- motor_fwd  out  1  drum forward
- motor_rev  out  1  drum reverse
- busy  out  1  state is not IDLE
- fault  out  1  sticky illegal-instruction flag

Behaviour:
- Reset:
  - pc=0, state IDLE, all registers 0.
  - All actuators 0, busy=0, fault=0.
- Opcodes: halt 00, wait 11, fill 12, release 13, forward 14, reverse 15, set 21, dec 22, j 30, jz 31, jnz 32.
- States:
  - IDLE: pc held.
  - EXEC: decode the instr at the current pc.
  - TIMED: timed operation running.
- IDLE:
  - start=1 and abort=0 -> pc<=START_ADDR, go to EXEC.
  - start is ignored in every other state.
- EXEC (one cycle per instruction):
  - halt -> IDLE, pc held at the halt address.
  - set -> R[idx]<=imm, pc+1.
  - dec -> R[idx]<=R[idx]-1, saturating at 0; pc+1.
  - j -> pc<=imm[ADDR_WIDTH-1:0].
  - jz -> branch to imm if R[idx]==0, else pc+1.
  - jnz -> branch to imm if R[idx]!=0, else pc+1.
  - Branches test the register value before any write in the same cycle.
  - Timed ops (wait/fill/release/forward/reverse) with imm!=0: timer<=imm, assert the op's actuator (wait asserts none), go to TIMED.
  - Timed ops with imm==0: no actuator, pc+1, stay in EXEC.
  - Unknown opcode, or idx>=NUM_REGS on set/dec/jz/jnz: fault<=1, go to IDLE, pc held.
- TIMED:
  - Each tick decrements timer.
  - A tick with timer==1: timer<=0, actuator off, pc+1, go to EXEC, all on the same edge.
  - A tick during the EXEC cycle is ignored.
  - Run length: an N-tick op keeps its actuator high from the edge after EXEC until the Nth tick edge.
- Actuator rules:
  - Actuators are registered.
  - At most one actuator is high at any time.
  - motor_fwd and motor_rev are never high together, including across back-to-back forward/reverse (the actuator drops for at least the EXEC cycle).
- abort:
  - Priority over everything except rst.
  - Next edge: all actuators 0, state IDLE, pc held, registers kept.
- fault:
  - Cleared only by rst, or by a start pulse accepted in IDLE.
- pc wrap: pc = 2^ADDR_WIDTH-1 followed by pc+1 gives 0.
- rst mid-operation: same as the reset values, asserted on the next edge.

Decomposition:
- Shared package wm_pkg:
  - Opcode localparams and field slice positions.
  - State enum.
  - Register width (16).
- Sub-module wm_timer:
  - Ports: load, load value, tick, done.
  - Holds the 16-bit countdown.
- Register file and decode stay inline in wm_core.

Test Plan:
- Program "fill 3; halt" at 2..3, start:
  - fill_valve is high for exactly 3 ticks.
  - pc goes 2->3; then IDLE, busy=0.
- "set R0=2; forward 1; dec R0; jnz R0->3; halt":
  - motor_fwd pulses twice.
  - R0 ends at 0; halts at the halt address.
- "forward 2; reverse 2" back-to-back:
  - motor_fwd and motor_rev are never both 1.
  - Gap of at least 1 cycle between them.
- abort during "release 100" after 5 ticks:
  - drain_valve=0 on the next edge, IDLE, pc held.
  - A subsequent start restarts at pc=2.
- Opcode 8'h7F, or "set" with idx=5:
  - fault=1, IDLE.
  - The next start clears fault and runs from 2.
- "wait 0; dec R3 (R3=0); j 0" then start:
  - wait 0 takes a single cycle.
  - R3 stays 0.
  - pc=0 halts (mem[0]=0), busy=0.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared opcodes, instruction field positions and FSM states for the washing-machine core.
// Latency: n/a (definitions only).  Backpressure: n/a.
package wm_pkg;

    localparam int REG_WIDTH = 16;

    // instruction layout: [31:16] imm16, [15:8] register index, [7:0] opcode
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 7;
    localparam int IDX_LSB = 8;
    localparam int IDX_MSB = 15;
    localparam int IMM_LSB = 16;
    localparam int IMM_MSB = 31;

    localparam logic [7:0] OP_HALT    = 8'h00;
    localparam logic [7:0] OP_WAIT    = 8'h11;
    localparam logic [7:0] OP_FILL    = 8'h12;
    localparam logic [7:0] OP_RELEASE = 8'h13;
    localparam logic [7:0] OP_FWD     = 8'h14;
    localparam logic [7:0] OP_REV     = 8'h15;
    localparam logic [7:0] OP_SET     = 8'h21;
    localparam logic [7:0] OP_DEC     = 8'h22;
    localparam logic [7:0] OP_J       = 8'h30;
    localparam logic [7:0] OP_JZ      = 8'h31;
    localparam logic [7:0] OP_JNZ     = 8'h32;

    // bit positions in the one-hot actuator vector
    localparam int ACT_FILL  = 0;
    localparam int ACT_DRAIN = 1;
    localparam int ACT_FWD   = 2;
    localparam int ACT_REV   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TIMED = 2'd2
    } state_t;

    function automatic logic is_timed(input logic [7:0] op);
        return (op == OP_WAIT) || (op == OP_FILL) || (op == OP_RELEASE) ||
               (op == OP_FWD)  || (op == OP_REV);
    endfunction

    function automatic logic [3:0] act_of(input logic [7:0] op);
        logic [3:0] a;
        a = 4'b0000;
        case (op)
            OP_FILL:    a[ACT_FILL]  = 1'b1;
            OP_RELEASE: a[ACT_DRAIN] = 1'b1;
            OP_FWD:     a[ACT_FWD]   = 1'b1;
            OP_REV:     a[ACT_REV]   = 1'b1;
            default:    a = 4'b0000;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wm_timer.sv
// Tick-paced 16-bit countdown for timed operations.
// Latency: load takes effect next edge; done is combinational on the final tick.  Backpressure: none.
module wm_timer
    import wm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] load_val,
    input  logic                 tick,
    output logic                 done
);

    logic [REG_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = tick && (cnt == REG_WIDTH'(1));

endmodule

// File: rtl/wm_core.sv
// Register-machine execution core: fetches from the ROM at pc, runs loops and tick-timed actuator ops.
// Latency: one cycle per instruction in EXEC, timed ops hold until their last tick.  Backpressure: none.
module wm_core
    import wm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_REGS    = 4,
    parameter int START_ADDR  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   tick,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   fill_valve,
    output logic                   drain_valve,
    output logic                   motor_fwd,
    output logic                   motor_rev,
    output logic                   busy,
    output logic                   fault
);

    localparam int         RIDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] IDX_LIM = 8'(NUM_REGS);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d, pc_inc;
    logic [3:0]              act_q, act_d;
    logic                    fault_q, fault_d;
    logic [REG_WIDTH-1:0]    regs [NUM_REGS];

    logic [7:0]              op;
    logic [7:0]              idx;
    logic [REG_WIDTH-1:0]    imm;
    logic [RIDX_W-1:0]       ridx;
    logic                    idx_ok;
    logic [REG_WIDTH-1:0]    rval;

    logic                    reg_we;
    logic [REG_WIDTH-1:0]    reg_wval;
    logic                    tmr_load;
    logic                    tmr_done;

    assign op     = instr[OP_MSB:OP_LSB];
    assign idx    = instr[IDX_MSB:IDX_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign ridx   = idx[RIDX_W-1:0];
    assign idx_ok = (idx < IDX_LIM);
    assign rval   = regs[ridx];
    assign pc_inc = pc_q + 1'b1;

    wm_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (imm),
        .tick     (tick),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        act_d    = act_q;
        fault_d  = fault_q;
        reg_we   = 1'b0;
        reg_wval = rval;
        tmr_load = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            act_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc_d    = ADDR_WIDTH'(START_ADDR);
                        fault_d = 1'b0;
                        state_d = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    act_d = '0;
                    if (op == OP_HALT) begin
                        state_d = ST_IDLE;
                    end else if (is_timed(op)) begin
                        if (imm != '0) begin
                            tmr_load = 1'b1;
                            act_d    = act_of(op);
                            state_d  = ST_TIMED;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end else if (op == OP_J) begin
                        pc_d = imm[ADDR_WIDTH-1:0];
                    end else if ((op == OP_SET || op == OP_DEC || op == OP_JZ || op == OP_JNZ) && idx_ok) begin
                        pc_d = pc_inc;
                        case (op)
                            OP_SET: begin
                                reg_we   = 1'b1;
                                reg_wval = imm;
                            end
                            OP_DEC: begin
                                reg_we   = 1'b1;
                                reg_wval = (rval == '0) ? '0 : rval - 1'b1;
                            end
                            OP_JZ:   if (rval == '0) pc_d = imm[ADDR_WIDTH-1:0];
                            default: if (rval != '0) pc_d = imm[ADDR_WIDTH-1:0];
                        endcase
                    end else begin
                        // unknown opcode or register index out of range
                        fault_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                ST_TIMED: begin
                    if (tmr_done) begin
                        act_d   = '0;
                        pc_d    = pc_inc;
                        state_d = ST_EXEC;
                    end
                end

                default: begin
                    act_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            act_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            act_q   <= act_d;
            fault_q <= fault_d;
            if (reg_we) begin
                regs[ridx] <= reg_wval;
            end
        end
    end

    assign pc          = pc_q;
    assign fill_valve  = act_q[ACT_FILL];
    assign drain_valve = act_q[ACT_DRAIN];
    assign motor_fwd   = act_q[ACT_FWD];
    assign motor_rev   = act_q[ACT_REV];
    assign busy        = (state_q != ST_IDLE);
    assign fault       = fault_q;

endmodule

// File: tb/tb_wm_core.sv
// Bench for wm_core: single-instruction vector table, directed program sequences, random run vs ISA model.
module tb_wm_core;

    logic        clk = 1'b0;
    logic        rst, start, abort, tick;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        fill_valve, drain_valve, motor_fwd, motor_rev, busy, fault;

    logic [31:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    assign instr = mem[pc];

    wm_core dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick), .instr(instr),
        .pc(pc), .fill_valve(fill_valve), .drain_valve(drain_valve), .motor_fwd(motor_fwd),
        .motor_rev(motor_rev), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ISA reference model (mode 0 idle, 1 executing, 2 timed) ----------------
    int m_mode, m_pc, m_rem, m_act;
    int m_r [4];
    bit m_fault;

    function automatic void model_reset();
        m_mode = 0; m_pc = 0; m_rem = 0; m_act = 0; m_fault = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
    endfunction

    task automatic model_step(input bit st, input bit ab, input bit tk);
        logic [31:0] w;
        int op, idx, imm;
        w   = mem[m_pc];
        op  = int'(w[7:0]);
        idx = int'(w[15:8]);
        imm = int'(w[31:16]);
        if (ab) begin
            m_mode = 0; m_act = 0;
        end else if (m_mode == 0) begin
            if (st) begin m_pc = 2; m_mode = 1; m_fault = 0; end
        end else if (m_mode == 2) begin
            if (tk) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_act = 0; m_pc = (m_pc + 1) % 256; m_mode = 1; end
            end
        end else begin
            case (op)
                'h00: m_mode = 0;
                'h11, 'h12, 'h13, 'h14, 'h15:
                    if (imm != 0) begin m_rem = imm; m_act = op - 'h11; m_mode = 2; end
                    else m_pc = (m_pc + 1) % 256;
                'h30: m_pc = imm % 256;
                'h21, 'h22, 'h31, 'h32:
                    if (idx >= 4) begin m_fault = 1; m_mode = 0; end
                    else begin
                        case (op)
                            'h21: begin m_r[idx] = imm; m_pc = (m_pc + 1) % 256; end
                            'h22: begin if (m_r[idx] > 0) m_r[idx] = m_r[idx] - 1; m_pc = (m_pc + 1) % 256; end
                            'h31: m_pc = (m_r[idx] == 0) ? imm % 256 : (m_pc + 1) % 256;
                            default: m_pc = (m_r[idx] != 0) ? imm % 256 : (m_pc + 1) % 256;
                        endcase
                    end
                default: begin m_fault = 1; m_mode = 0; end
            endcase
        end
    endtask

    function automatic logic [31:0] model_out();
        return {18'd0, 8'(m_pc), m_act == 1, m_act == 2, m_act == 3, m_act == 4, m_mode != 0, m_fault};
    endfunction

    function automatic logic [31:0] dut_out();
        return {18'd0, pc, fill_valve, drain_valve, motor_fwd, motor_rev, busy, fault};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] idx, input logic [15:0] imm);
        return {imm, idx, op};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_pulse();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic tick_pulse();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  epc;
        logic [3:0]  eact;   // {fill, drain, fwd, rev}
        logic        ebusy;
        logic        efault;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n, c, last_f, first_r;
        bit pf, both, st, ab, tk, rs;

        // state after first EXEC cycle of a single instruction at address 2, registers all zero
        vt[0]  = '{mk(8'h00, 8'd0, 16'd0),      8'h02, 4'b0000, 1'b0, 1'b0};
        vt[1]  = '{mk(8'h11, 8'd0, 16'd5),      8'h02, 4'b0000, 1'b1, 1'b0};
        vt[2]  = '{mk(8'h12, 8'd0, 16'd5),      8'h02, 4'b1000, 1'b1, 1'b0};
        vt[3]  = '{mk(8'h13, 8'd0, 16'd5),      8'h02, 4'b0100, 1'b1, 1'b0};
        vt[4]  = '{mk(8'h14, 8'd0, 16'd5),      8'h02, 4'b0010, 1'b1, 1'b0};
        vt[5]  = '{mk(8'h15, 8'd0, 16'd5),      8'h02, 4'b0001, 1'b1, 1'b0};
        vt[6]  = '{mk(8'h12, 8'd0, 16'd0),      8'h03, 4'b0000, 1'b1, 1'b0};
        vt[7]  = '{mk(8'h21, 8'd1, 16'd7),      8'h03, 4'b0000, 1'b1, 1'b0};
        vt[8]  = '{mk(8'h21, 8'd5, 16'd7),      8'h02, 4'b0000, 1'b0, 1'b1};
        vt[9]  = '{mk(8'h22, 8'd0, 16'd0),      8'h03, 4'b0000, 1'b1, 1'b0};
        vt[10] = '{mk(8'h30, 8'd0, 16'h1240),   8'h40, 4'b0000, 1'b1, 1'b0};
        vt[11] = '{mk(8'h31, 8'd0, 16'h0050),   8'h50, 4'b0000, 1'b1, 1'b0};
        vt[12] = '{mk(8'h32, 8'd0, 16'h0050),   8'h03, 4'b0000, 1'b1, 1'b0};
        vt[13] = '{mk(8'h7F, 8'd0, 16'd0),      8'h02, 4'b0000, 1'b0, 1'b1};
        vt[14] = '{mk(8'h32, 8'd4, 16'h0050),   8'h02, 4'b0000, 1'b0, 1'b1};

        clear_mem();
        do_reset();
        check("reset", dut_out(), 32'h0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            clear_mem();
            mem[2] = vt[i].ins;
            start_pulse();
            cyc();
            check($sformatf("vec%0d", i), dut_out(),
                  {18'd0, vt[i].epc, vt[i].eact, vt[i].ebusy, vt[i].efault});
        end

        // fill 3; halt : valve held for exactly three ticks
        do_reset(); clear_mem();
        mem[2] = mk(8'h12, 8'd0, 16'd3);
        start_pulse(); cyc();
        check("fill_on", {pc, fill_valve}, {8'd2, 1'b1});
        cyc(); tick_pulse();
        check("fill_t1", 32'(fill_valve), 32'd1);
        tick_pulse();
        check("fill_t2", 32'(fill_valve), 32'd1);
        tick_pulse();
        check("fill_t3", {pc, fill_valve, busy}, {8'd3, 1'b0, 1'b1});
        cyc();
        check("fill_halt", {pc, busy}, {8'd3, 1'b0});

        // loop: set R0=2; forward 1; dec R0; jnz R0->3; halt
        do_reset(); clear_mem();
        mem[2] = mk(8'h21, 8'd0, 16'd2);
        mem[3] = mk(8'h14, 8'd0, 16'd1);
        mem[4] = mk(8'h22, 8'd0, 16'd0);
        mem[5] = mk(8'h32, 8'd0, 16'd3);
        start_pulse();
        n = 0; pf = 1'b0;
        for (c = 0; c < 200 && busy; c++) begin
            tick = (c % 3 == 0);
            cyc();
            if (motor_fwd && !pf) n++;
            pf = motor_fwd;
        end
        tick = 1'b0;
        check("loop_pulses", 32'(n), 32'd2);
        check("loop_halt", {pc, busy, fault}, {8'd6, 1'b0, 1'b0});

        // forward 2; reverse 2 back to back
        do_reset(); clear_mem();
        mem[2] = mk(8'h14, 8'd0, 16'd2);
        mem[3] = mk(8'h15, 8'd0, 16'd2);
        start_pulse();
        both = 1'b0; last_f = -1; first_r = -1;
        for (c = 0; c < 100 && busy; c++) begin
            tick = (c % 2 == 1);
            cyc();
            if (motor_fwd && motor_rev) both = 1'b1;
            if (motor_fwd) last_f = c;
            if (motor_rev && first_r < 0) first_r = c;
        end
        tick = 1'b0;
        check("fr_overlap", 32'(both), 32'd0);
        check("fr_gap", 32'(last_f >= 0 && first_r > last_f + 1), 32'd1);
        check("fr_done", {pc, busy}, {8'd4, 1'b0});

        // abort during release 100 after 5 ticks, then restart, then reset mid-op
        do_reset(); clear_mem();
        mem[2] = mk(8'h13, 8'd0, 16'd100);
        start_pulse(); cyc();
        for (int k = 0; k < 5; k++) tick_pulse();
        check("rel_run", {pc, drain_valve, busy}, {8'd2, 1'b1, 1'b1});
        abort = 1'b1; cyc(); abort = 1'b0;
        check("abort", {pc, drain_valve, busy}, {8'd2, 1'b0, 1'b0});
        start_pulse();
        check("restart", {pc, drain_valve, busy}, {8'd2, 1'b0, 1'b1});
        cyc();
        check("restart_run", 32'(drain_valve), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_midop", dut_out(), 32'h0);

        // fault then clearing start
        do_reset(); clear_mem();
        mem[2] = mk(8'h7F, 8'd0, 16'd0);
        start_pulse(); cyc();
        check("fault_set", {pc, busy, fault}, {8'd2, 1'b0, 1'b1});
        mem[2] = mk(8'h11, 8'd0, 16'd0);
        start_pulse();
        check("fault_clr", {pc, busy, fault}, {8'd2, 1'b1, 1'b0});
        cyc(); cyc();
        check("fault_run", {pc, busy, fault}, {8'd3, 1'b0, 1'b0});

        // wait 0; dec R3; j 0 with halt at 0
        do_reset(); clear_mem();
        mem[2] = mk(8'h11, 8'd0, 16'd0);
        mem[3] = mk(8'h22, 8'd3, 16'd0);
        mem[4] = mk(8'h30, 8'd0, 16'd0);
        start_pulse(); cyc();
        check("wait0", {pc, busy}, {8'd3, 1'b1});
        cyc(); cyc();
        check("j0", {pc, busy}, {8'd0, 1'b1});
        cyc();
        check("halt0", {pc, busy, fault}, {8'd0, 1'b0, 1'b0});

        // pc wrap 255 -> 0
        do_reset(); clear_mem();
        mem[2]   = mk(8'h30, 8'd0, 16'h00FF);
        mem[255] = mk(8'h12, 8'd0, 16'd0);
        start_pulse(); cyc();
        check("wrap_ff", {pc, busy}, {8'd255, 1'b1});
        cyc();
        check("wrap_00", {pc, busy}, {8'd0, 1'b1});

        // random programs and inputs against the model
        do_reset();
        for (int i = 0; i < 256; i++) begin
            int sel;
            logic [7:0] op, idx;
            logic [15:0] imm;
            sel = $urandom_range(0, 13);
            idx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            imm = 16'($urandom_range(0, 3));
            case (sel)
                0:  op = 8'h00;
                1:  op = 8'h11;
                2:  op = 8'h12;
                3:  op = 8'h13;
                4:  op = 8'h14;
                5:  op = 8'h15;
                6, 7: op = 8'h21;
                8, 9: op = 8'h22;
                10: begin op = 8'h30; imm = 16'($urandom_range(0, 65535)); end
                11: begin op = 8'h31; imm = 16'($urandom_range(0, 65535)); end
                12: begin op = 8'h32; imm = 16'($urandom_range(0, 65535)); end
                default: op = 8'($urandom_range(0, 255));
            endcase
            mem[i] = mk(op, idx, imm);
        end
        for (int k = 0; k < 4000; k++) begin
            check("rand", dut_out(), model_out());
            st = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 99) == 0);
            tk = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 499) == 0);
            start = st; abort = ab; tick = tk; rst = rs;
            if (rs) model_reset();
            else model_step(st, ab, tk);
            cyc();
        end
        check("rand_end", dut_out(), model_out());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
